muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M/RV64M multiply/divide unit attached beside the ALU in the execute stage. It accepts one operation through a valid/ready handshake, computes it over multiple cycles with a configurable number of result bits per cycle, and returns the result with a caller-supplied tag. While an operation is in flight it raises `busy` so the controller stalls the front end. A `flush` input cancels an in-flight operation on a branch mispredict.

## Interface
- `XLEN`, 32: operand/result width; 32 or 64.
- `BITS_PER_CYCLE`, 1: quotient/product bits retired per iteration; one of 1, 2, 4; must divide `XLEN`.
- `TAG_W`, 5: width of the pass-through tag (destination register index).
- One clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `reqValid`  in  1  operation request.
- `reqReady`  out  1  unit can accept; equals `state==IDLE && !rst`.
- `op`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  in  XLEN  bypassed operand 1 (multiplicand/dividend).
- `rs2`  in  XLEN  bypassed operand 2 (multiplier/divisor).
- `reqTag`  in  TAG_W  tag captured with the request.
- `flush`  in  1  cancel in-flight operation.
- `busy`  out  1  `state != IDLE`; stall request to controller.
- `respValid`  out  1  one-cycle result pulse.
- `result`  out  XLEN  registered result; holds until the next response.
- `respTag`  out  TAG_W  tag of the current/last response.

## Operation
- Accept when `reqValid && reqReady && !flush` is sampled on a rising edge. Capture op, tag, operand signs, and absolute values:
  - signed for MUL, MULH, DIV, REM;
  - rs1 only for MULHSU;
  - none for the unsigned ops.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE -> CALC on normal accept, iteration counter cleared.
- IDLE -> DONE on special divide cases, with the result loaded directly:
  - rs2 == 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - DIV with rs1 == most-negative and rs2 == -1: quotient = rs1; REM in the same case: 0.
- CALC: each edge retires `BITS_PER_CYCLE` bits.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring divide, one trial subtract per bit.
  - After N = XLEN/BITS_PER_CYCLE iterations, go to FIXUP.
- FIXUP: negate the product if operand signs differ (signed ops). Negate the quotient if signs differ (DIV). Give the remainder the dividend's sign (REM). Select the word:
  - MUL: low word.
  - MULH*: high word.
  - Register the result and go to DONE.
- DONE: `respValid`=1 and `respTag` valid for exactly one cycle, then IDLE.
- `flush` in any non-IDLE state forces IDLE on the next edge. It masks `respValid` combinationally in the same cycle (`respValid = state==DONE && !flush`) and leaves `result` unchanged.
- `flush` with `reqValid` in IDLE: the request is not accepted.
- `reqReady` is low in DONE; back-to-back operations are separated by one IDLE cycle.
- All arithmetic is modulo 2^XLEN except the internal 2*XLEN accumulator and the (XLEN+1)-bit remainder.

## Timing
- Reset values (while `rst` high and on the first cycle after): state IDLE, `reqReady`=0 during reset and 1 after, `busy`=0, `respValid`=0, `result`=0, `respTag`=0, counter 0.
- `rst` mid-operation aborts with no response.
- Normal latency: accept edge E0; iterations at E1..EN; FIXUP at E(N+1). `respValid` is high in the cycle after E(N+1), then `reqReady` goes high after E(N+2).
- Special-case latency: `respValid` is high in the cycle after E0.
- `busy` rises in the cycle after the accept edge and falls in the cycle after the DONE->IDLE (or flush) edge.
- `result`/`respTag` are registered; there is no combinational path from inputs to them.

## Test plan
- XLEN=32, BPC=1: MUL rs1=7, rs2=0xFFFFFFFD, tag 3 -> `result`=0xFFFFFFEB, `respTag`=3, `respValid` exactly 33 cycles after accept, `busy` high for 34 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0x80000000/3 -> 0x2AAAAAAA; REMU -> 2.
- Special cases, each with `respValid` one cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF;
  - REMU 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
  - REM of the same -> 0.
- Flush and reset:
  - `flush` on iteration 10 -> no `respValid`, `busy`=0 next cycle, `result` unchanged.
  - Immediate new MUL 6*7, tag 9 -> 42, tag 9.
  - `rst` mid-CALC -> all outputs at reset values.
- BPC=4, then XLEN=64 with BPC=2: random signed/unsigned vectors against a reference model. Latency is 9 and 33 cycles respectively.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit with a tagged valid/ready handshake
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] reqTag,
    input  logic             flush,
    output logic             busy,
    output logic             respValid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] respTag
);
    localparam int N = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} stateT;
    stateT state, stateNext;
    logic [2:0] opReg;
    logic [TAG_W-1:0] tagReg;
    logic neg1, neg2;
    logic [XLEN-1:0] opB;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0] rem;
    logic [CW-1:0] cnt;
    logic accept, sgn1, sgn2, neg1In, neg2In, divZero, divOvf, special;
    logic [XLEN-1:0] abs1, abs2, specVal, fixVal, quo, remOut, dQ;
    logic [2*XLEN-1:0] prod, mAcc;
    logic [XLEN:0] dR, mSum;
    logic [XLEN+1:0] trial;

    assign reqReady = state == IDLE && !rst;
    assign busy = state != IDLE;
    assign respValid = state == DONE && !flush;
    assign accept = reqValid && reqReady && !flush;
    assign sgn1 = op[2] ? !op[0] : op != 3'b011;
    assign sgn2 = op[2] ? !op[0] : !op[1];
    assign neg1In = sgn1 && rs1[XLEN-1];
    assign neg2In = sgn2 && rs2[XLEN-1];
    assign abs1 = neg1In ? -rs1 : rs1;
    assign abs2 = neg2In ? -rs2 : rs2;
    assign divZero = op[2] && rs2 == '0;
    assign divOvf = op[2] && !op[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && &rs2;
    assign special = divZero || divOvf;
    assign specVal = divZero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);

    // acc holds multiplier/product for MUL*, and dividend/quotient in its low word for DIV*
    always_comb begin
        mAcc = acc;
        dQ = acc[XLEN-1:0];
        dR = rem;
        mSum = '0;
        trial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            mSum = {1'b0, mAcc[2*XLEN-1:XLEN]} + (mAcc[0] ? {1'b0, opB} : '0);
            mAcc = {mSum, mAcc[XLEN-1:1]};
            dR = {dR[XLEN-1:0], dQ[XLEN-1]};
            trial = {1'b0, dR} - {2'b0, opB};
            dQ = {dQ[XLEN-2:0], !trial[XLEN+1]};
            dR = trial[XLEN+1] ? dR : trial[XLEN:0];
        end
    end

    assign prod = (neg1 ^ neg2) ? -acc : acc;
    assign quo = (neg1 ^ neg2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign remOut = neg1 ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    assign fixVal = opReg[2] ? (opReg[1] ? remOut : quo)
                             : (opReg[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = accept ? (special ? DONE : CALC) : IDLE;
            CALC:    stateNext = cnt == CW'(N - 1) ? FIXUP : CALC;
            FIXUP:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flush && state != IDLE) stateNext = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            result <= '0;
            respTag <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                opReg <= op;
                tagReg <= reqTag;
                neg1 <= neg1In;
                neg2 <= neg2In;
                opB <= op[2] ? abs2 : abs1;
                acc <= {{XLEN{1'b0}}, op[2] ? abs1 : abs2};
                rem <= '0;
                cnt <= '0;
                if (special) begin
                    result <= specVal;
                    respTag <= reqTag;
                end
            end
            if (state == CALC) begin
                acc <= opReg[2] ? {{XLEN{1'b0}}, dQ} : mAcc;
                rem <= dR;
                cnt <= cnt + CW'(1);
            end
            if (state == FIXUP && !flush) begin
                result <= fixVal;
                respTag <= tagReg;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit in three XLEN/BITS_PER_CYCLE configurations
module tb_muldiv_unit;
    logic clk = 0, rst = 1, flush = 0;
    logic [2:0] op = '0;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic [4:0] reqTag = '0;
    logic rv0 = 0, rv1 = 0, rv2 = 0;
    logic rdy0, rdy1, rdy2, busy0, busy1, busy2, resp0, resp1, resp2;
    logic [31:0] res0, res1;
    logic [63:0] res2;
    logic [4:0] tag0, tag1, tag2;
    int checks = 0, errors = 0;
    logic [63:0] expRes[$];
    logic [4:0] expTag[$];
    int bc, nr;
    logic [63:0] held, a, b;
    logic [2:0] o;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut0 (
        .clk(clk), .rst(rst), .reqValid(rv0), .reqReady(rdy0), .op(op), .rs1(rs1[31:0]), .rs2(rs2[31:0]),
        .reqTag(reqTag), .flush(flush), .busy(busy0), .respValid(resp0), .result(res0), .respTag(tag0));
    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) dut1 (
        .clk(clk), .rst(rst), .reqValid(rv1), .reqReady(rdy1), .op(op), .rs1(rs1[31:0]), .rs2(rs2[31:0]),
        .reqTag(reqTag), .flush(flush), .busy(busy1), .respValid(resp1), .result(res1), .respTag(tag1));
    muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(2), .TAG_W(5)) dut2 (
        .clk(clk), .rst(rst), .reqValid(rv2), .reqReady(rdy2), .op(op), .rs1(rs1), .rs2(rs2),
        .reqTag(reqTag), .flush(flush), .busy(busy2), .respValid(resp2), .result(res2), .respTag(tag2));

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] getRes(int k);
        return k == 0 ? {32'b0, res0} : k == 1 ? {32'b0, res1} : res2;
    endfunction
    function automatic logic [4:0] getTag(int k);
        return k == 0 ? tag0 : k == 1 ? tag1 : tag2;
    endfunction
    function automatic logic getBusy(int k);
        return k == 0 ? busy0 : k == 1 ? busy1 : busy2;
    endfunction
    function automatic logic getResp(int k);
        return k == 0 ? resp0 : k == 1 ? resp1 : resp2;
    endfunction
    function automatic logic getReady(int k);
        return k == 0 ? rdy0 : k == 1 ? rdy1 : rdy2;
    endfunction
    task automatic setRv(input int k, input logic v);
        if (k == 0) rv0 = v;
        else if (k == 1) rv1 = v;
        else rv2 = v;
    endtask

    // Reference: sign-extend into 128 bits and use native multiply/divide
    function automatic logic [63:0] model(int xl, logic [2:0] fo, logic [63:0] fa, logic [63:0] fb);
        logic [127:0] m, ua, ub, sa, sb, p;
        m = (128'd1 << xl) - 128'd1;
        ua = {64'b0, fa} & m;
        ub = {64'b0, fb} & m;
        sa = ua[xl-1] ? (ua | ~m) : ua;
        sb = ub[xl-1] ? (ub | ~m) : ub;
        p = '0;
        case (fo)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >> xl;
            3'd2: p = (sa * ub) >> xl;
            3'd3: p = (ua * ub) >> xl;
            3'd4: if (ub == 0) p = m; else p = $signed(sa) / $signed(sb);
            3'd5: if (ub == 0) p = m; else p = ua / ub;
            3'd6: if (ub == 0) p = ua; else p = $signed(sa) % $signed(sb);
            default: if (ub == 0) p = ua; else p = ua % ub;
        endcase
        return p[63:0] & m[63:0];
    endfunction

    task automatic run(input int k, input logic [2:0] ro, input logic [63:0] ra, input logic [63:0] rb,
                       input logic [4:0] t, input logic [63:0] exp, input int flushAt,
                       output int busyCyc, output int nResp);
        int xl, n, lat, latExp;
        logic [63:0] m, ma, mb;
        xl = k == 2 ? 64 : 32;
        n = xl / (k == 0 ? 1 : k == 1 ? 4 : 2);
        m = xl == 64 ? '1 : 64'hFFFF_FFFF;
        ma = ra & m;
        mb = rb & m;
        latExp = (ro[2] && (mb == 0 || (!ro[0] && ma == (64'd1 << (xl - 1)) && mb == m))) ? 0 : n + 1;
        @(negedge clk);
        op = ro; rs1 = ra; rs2 = rb; reqTag = t;
        check("ready_idle", 64'(getReady(k)), 64'd1);
        if (flushAt < 0) begin
            expRes.push_back(exp);
            expTag.push_back(t);
        end
        setRv(k, 1);
        @(posedge clk);
        #1 setRv(k, 0);
        lat = -1; busyCyc = 0; nResp = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!getBusy(k)) break;
            busyCyc++;
            if (getResp(k)) begin
                nResp++;
                if (lat < 0) lat = i;
                check("ready_in_done", 64'(getReady(k)), 64'd0);
                if (expRes.size() > 0) begin
                    check("result", getRes(k), expRes.pop_front());
                    check("resp_tag", 64'(getTag(k)), 64'(expTag.pop_front()));
                end else check("spurious_resp", 64'(getResp(k)), 64'd0);
            end
            flush = i == flushAt;
        end
        flush = 0;
        check("busy_end", 64'(getBusy(k)), 64'd0);
        if (flushAt < 0) begin
            check("latency", 64'(lat), 64'(latExp));
            check("busy_cycles", 64'(busyCyc), 64'(latExp + 1));
            check("resp_count", 64'(nResp), 64'd1);
        end
        expRes.delete();
        expTag.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(rdy0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_resp", 64'(resp0), 64'd0);
        check("rst_result", getRes(0), 64'd0);
        check("rst_tag", 64'(tag0), 64'd0);
        rst = 0;
        @(negedge clk);
        check("post_rst_ready", {61'b0, rdy0, rdy1, rdy2}, 64'd7);
        run(0, 3'd0, 64'd7, 64'hFFFF_FFFD, 5'd3, 64'hFFFF_FFEB, -1, bc, nr);
        run(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 5'd4, 64'h4000_0000, -1, bc, nr);
        run(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd5, 64'hFFFF_FFFE, -1, bc, nr);
        run(0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd6, 64'hFFFF_FFFF, -1, bc, nr);
        run(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFD, -1, bc, nr);
        run(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF, -1, bc, nr);
        run(0, 3'd5, 64'h8000_0000, 64'd3, 5'd10, 64'h2AAA_AAAA, -1, bc, nr);
        run(0, 3'd7, 64'h8000_0000, 64'd3, 5'd11, 64'd2, -1, bc, nr);
        run(0, 3'd5, 64'd5, 64'd0, 5'd12, 64'hFFFF_FFFF, -1, bc, nr);
        run(0, 3'd7, 64'd5, 64'd0, 5'd13, 64'd5, -1, bc, nr);
        run(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd14, 64'h8000_0000, -1, bc, nr);
        run(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd15, 64'd0, -1, bc, nr);
        held = getRes(0);
        run(0, 3'd0, 64'd1234, 64'd5678, 5'd20, 64'd0, 10, bc, nr);
        check("flush_busy_cycles", 64'(bc), 64'd11);
        check("flush_no_resp", 64'(nr), 64'd0);
        check("flush_result_held", getRes(0), held);
        run(0, 3'd0, 64'd6, 64'd7, 5'd9, 64'd42, -1, bc, nr);
        @(negedge clk);
        op = 3'd0; rs1 = 64'd3; rs2 = 64'd3; flush = 1; rv0 = 1;
        @(posedge clk);
        #1 begin flush = 0; rv0 = 0; end
        @(negedge clk);
        check("flush_idle_busy", 64'(busy0), 64'd0);
        check("flush_idle_resp", 64'(resp0), 64'd0);
        rs1 = 64'd100; rs2 = 64'd3; op = 3'd5; reqTag = 5'd17; rv0 = 1;
        @(posedge clk);
        #1 rv0 = 0;
        repeat (5) @(negedge clk);
        check("mid_calc_busy", 64'(busy0), 64'd1);
        rst = 1;
        @(negedge clk);
        check("rst_mid_ready", 64'(rdy0), 64'd0);
        check("rst_mid_busy", 64'(busy0), 64'd0);
        check("rst_mid_resp", 64'(resp0), 64'd0);
        check("rst_mid_result", getRes(0), 64'd0);
        check("rst_mid_tag", 64'(tag0), 64'd0);
        rst = 0;
        @(negedge clk);
        check("rst_mid_ready_after", 64'(rdy0), 64'd1);
        for (int k = 1; k < 3; k++) begin
            for (int j = 0; j < 24; j++) begin
                int sel, xl;
                xl = k == 2 ? 64 : 32;
                o = 3'($urandom_range(0, 7));
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                sel = $urandom_range(0, 7);
                if (sel == 0) b = '0;
                if (sel == 1) begin a = 64'd1 << (xl - 1); b = '1; end
                if (sel == 2) b = 64'($urandom_range(1, 5));
                run(k, o, a, b, 5'($urandom_range(0, 31)), model(xl, o, a, b), -1, bc, nr);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
